if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage_pkg.sv | 23 ++
 rtl/if_fetch_stage.sv | 93 +++++++++
 tb/tb_if_fetch_stage.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline constants and the fetch-state encoding used by the IF stage
// and by the IF/ID and ID/EX flush logic.
package if_fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PIPE_RESET_PC  = 32'h0000_3000;
  localparam logic [XLEN-1:0] PIPE_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [XLEN-1:0] WORD_MASK      = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time and
// holds the returned word until IF/ID takes it. Redirects flush any fetch in
// flight; a NOP bubble is driven whenever no real instruction is held.
//
// state   | meaning
// --------+-------------------------------------------------------------
// FETCH   | request pc to imem, waiting for imem_ready
// WAIT    | request accepted, waiting for imem_rvalid
// HOLD    | word buffered and presented to IF/ID, waiting for !stall
// DISCARD | redirected while a response was outstanding; drop it on rvalid
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = PIPE_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = PIPE_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] Instruction_IN,
  output logic [XLEN-1:0] PC_Addr_IN,
  output logic            fetch_valid
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] buf_instr;
  logic [XLEN-1:0] buf_pc;
  logic            in_hold;

  // pc is kept word-aligned at every write, so it can drive the address directly.
  assign in_hold        = (state == HOLD) && !rst;
  assign imem_req       = (state == FETCH) && !redirect_valid && !rst;
  assign imem_addr      = pc;
  assign fetch_valid    = in_hold;
  assign Instruction_IN = in_hold ? buf_instr : NOP_INSTR;
  assign PC_Addr_IN     = rst ? RESET_PC : buf_pc;

  // Fetch FSM, PC register and next-PC selection; redirect outranks every
  // handshake and stall, reset outranks everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= word_align(RESET_PC);
      req_pc    <= word_align(RESET_PC);
      buf_instr <= NOP_INSTR;
      buf_pc    <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= word_align(redirect_pc);
      case (state)
        WAIT:    state <= imem_rvalid ? FETCH : DISCARD;
        HOLD:    state <= FETCH;
        // The outstanding response still has to be drained even while
        // further redirects arrive, otherwise the FSM would wait forever.
        DISCARD: if (imem_rvalid) state <= FETCH;
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            buf_instr <= imem_rdata;
            buf_pc    <= req_pc;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) state <= FETCH;
        end
        DISCARD: begin
          if (imem_rvalid) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a scoreboard of expected
// (pc, instruction) pairs is filled as memory responses are scheduled and
// drained by a monitor whenever IF/ID would consume a word.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction_IN;
  logic [31:0] PC_Addr_IN;
  logic        fetch_valid;

  fetch_t exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  bit     auto_mem = 1'b1;

  if_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .Instruction_IN (Instruction_IN),
    .PC_Addr_IN     (PC_Addr_IN),
    .fetch_valid    (fetch_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // One clock. With auto_mem set, a request accepted at this edge is answered
  // with rvalid in the following cycle (zero-wait memory).
  task automatic step();
    logic        acc;
    logic [31:0] a;
    #2;
    acc = imem_req && imem_ready;
    a   = imem_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_rvalid = acc;
      imem_rdata  = acc ? mem_word(a) : 32'hDEAD_BEEF;
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    fetch_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    exp_q.push_back(e);
  endtask

  // Scoreboard drain: a word is consumed whenever it is valid and not stalled.
  initial begin
    fetch_t e;
    forever begin
      @(negedge clk);
      if (!rst && fetch_valid && !stall) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_fetch: got pc=%h instr=%h, required no valid word", PC_Addr_IN, Instruction_IN);
        end else begin
          e = exp_q.pop_front();
          if ({PC_Addr_IN, Instruction_IN} !== {e.pc, e.instr}) begin
            n_fail++;
            $display("FAIL fetch_word: got pc=%h instr=%h, required pc=%h instr=%h",
                     PC_Addr_IN, Instruction_IN, e.pc, e.instr);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; auto_mem = 1'b1;
    step();
    step();
    n_tests++;
    if ({fetch_valid, imem_req, Instruction_IN, PC_Addr_IN} !== {1'b0, 1'b0, NOP, 32'h3000}) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b req=%b instr=%h pc=%h, required 0 0 %h 3000",
               fetch_valid, imem_req, Instruction_IN, PC_Addr_IN, NOP);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({imem_req, imem_addr, fetch_valid} !== {1'b1, 32'h3000, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_req: got req=%b addr=%h valid=%b, required 1 3000 0", imem_req, imem_addr, fetch_valid);
    end
  endtask

  task automatic test_zero_wait();
    imem_ready = 1'b1;
    stall      = 1'b0;
    for (int i = 0; i < 3; i++) push_exp(32'h3000 + 32'(4 * i));
    for (int i = 0; i < 9; i++) begin
      n_tests++;
      if (fetch_valid !== (i % 3 == 2)) begin
        n_fail++;
        $display("FAIL zw_valid_cycle%0d: got %b, required %b", i, fetch_valid, (i % 3 == 2));
      end
      if (i % 3 == 0) begin
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h3000 + 32'(4 * (i / 3))}) begin
          n_fail++;
          $display("FAIL zw_addr_cycle%0d: got req=%b addr=%h, required 1 %h", i, imem_req, imem_addr,
                   32'h3000 + 32'(4 * (i / 3)));
        end
      end
      step();
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL zw_drain: got %0d words left, required 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    push_exp(32'h300C);
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({fetch_valid, imem_req, PC_Addr_IN, Instruction_IN} !== {1'b1, 1'b0, 32'h300C, mem_word(32'h300C)}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got valid=%b req=%b pc=%h instr=%h, required 1 0 300c %h",
                 i, fetch_valid, imem_req, PC_Addr_IN, Instruction_IN, mem_word(32'h300C));
      end
      step();
    end
    stall = 1'b0;
    step();
    n_tests++;
    if ({fetch_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h3010}) begin
      n_fail++;
      $display("FAIL stall_release: got valid=%b req=%b addr=%h, required 0 1 3010", fetch_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    auto_mem = 1'b0;
    imem_rvalid = 1'b0;
    step();
    n_tests++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_wait_req: got %b, required 0", imem_req);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4001;
    step();
    redirect_valid = 1'b0;
    #1;
    n_tests++;
    if ({fetch_valid, imem_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL rw_discard: got valid=%b req=%b, required 0 0", fetch_valid, imem_req);
    end
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h3010);
    step();
    imem_rvalid = 1'b0;
    n_tests++;
    if ({fetch_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h4000}) begin
      n_fail++;
      $display("FAIL rw_target: got valid=%b req=%b addr=%h, required 0 1 4000", fetch_valid, imem_req, imem_addr);
    end
    push_exp(32'h4000);
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h4000);
    step();
    imem_rvalid = 1'b0;
    n_tests++;
    if ({fetch_valid, PC_Addr_IN} !== {1'b1, 32'h4000}) begin
      n_fail++;
      $display("FAIL rw_new_word: got valid=%b pc=%h, required 1 4000", fetch_valid, PC_Addr_IN);
    end
    step();
  endtask

  task automatic test_redirect_same_rvalid();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h5000;
    imem_rvalid    = 1'b1;
    imem_rdata     = mem_word(32'h4004);
    step();
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b0;
    #1;
    n_tests++;
    if ({fetch_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h5000}) begin
      n_fail++;
      $display("FAIL rsame: got valid=%b req=%b addr=%h, required 0 1 5000", fetch_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_hold();
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(32'h5000);
    step();
    imem_rvalid = 1'b0;
    stall       = 1'b1;
    n_tests++;
    if ({fetch_valid, PC_Addr_IN} !== {1'b1, 32'h5000}) begin
      n_fail++;
      $display("FAIL rh_hold: got valid=%b pc=%h, required 1 5000", fetch_valid, PC_Addr_IN);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6000;
    step();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    #1;
    n_tests++;
    if ({fetch_valid, imem_req, Instruction_IN, imem_addr} !== {1'b0, 1'b1, NOP, 32'h6000}) begin
      n_fail++;
      $display("FAIL rh_flush: got valid=%b req=%b instr=%h addr=%h, required 0 1 %h 6000",
               fetch_valid, imem_req, Instruction_IN, imem_addr, NOP);
    end
  endtask

  task automatic test_ready_low();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({imem_req, imem_addr, fetch_valid} !== {1'b1, 32'h6000, 1'b0}) begin
        n_fail++;
        $display("FAIL rl_cycle%0d: got req=%b addr=%h valid=%b, required 1 6000 0", i, imem_req, imem_addr, fetch_valid);
      end
      if (i == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
      end
      step();
      imem_rvalid = 1'b0;
    end
    n_tests++;
    if ({imem_req, imem_addr, fetch_valid} !== {1'b1, 32'h6000, 1'b0}) begin
      n_fail++;
      $display("FAIL rl_stray_rvalid: got req=%b addr=%h valid=%b, required 1 6000 0", imem_req, imem_addr, fetch_valid);
    end
    imem_ready = 1'b1;
    auto_mem   = 1'b1;
    push_exp(32'h6000);
    step();
    step();
    n_tests++;
    if ({fetch_valid, PC_Addr_IN} !== {1'b1, 32'h6000}) begin
      n_fail++;
      $display("FAIL rl_word: got valid=%b pc=%h, required 1 6000", fetch_valid, PC_Addr_IN);
    end
    step();
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h6004}) begin
      n_fail++;
      $display("FAIL rl_next: got req=%b addr=%h, required 1 6004", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    #1;
    n_tests++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_redirect_req: got %b, required 0", imem_req);
    end
    step();
    redirect_valid = 1'b0;
    #1;
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_fail++;
      $display("FAIL wrap_top: got req=%b addr=%h, required 1 fffffffc", imem_req, imem_addr);
    end
    push_exp(32'hFFFF_FFFC);
    step();
    step();
    n_tests++;
    if ({fetch_valid, PC_Addr_IN} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_fail++;
      $display("FAIL wrap_word: got valid=%b pc=%h, required 1 fffffffc", fetch_valid, PC_Addr_IN);
    end
    step();
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0000}) begin
      n_fail++;
      $display("FAIL wrap_zero: got req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    auto_mem    = 1'b0;
    imem_rvalid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_tests++;
    if ({fetch_valid, Instruction_IN, PC_Addr_IN, imem_req, imem_addr} !== {1'b0, NOP, 32'h3000, 1'b1, 32'h3000}) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got valid=%b instr=%h pc=%h req=%b addr=%h, required 0 %h 3000 1 3000",
               fetch_valid, Instruction_IN, PC_Addr_IN, imem_req, imem_addr, NOP);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_wait();
    test_redirect_same_rvalid();
    test_redirect_hold();
    test_ready_low();
    test_wrap();
    test_reset_mid_wait();
    step();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: got %0d words left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
